// File: rtl/cpu_pkg.sv
// Shared CPU constants: multiply/divide op codes (also used by the control unit's
// div_mul generation) and the mul/div engine state encoding.
package cpu_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement of a W-bit bus; used both to take operand
// magnitudes and to re-apply the sign to results.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide engine: magnitude shift-add multiply or restoring
// divide over WIDTH clocks, then one clock of sign correction into hi/lo.
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       div_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e          r_state;
    md_state_e          w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dbz;
    logic               r_done;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH+1:0]   w_rem_sh;
    logic [WIDTH+1:0]   w_trial;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = ~div_mul[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];

    md_sign_fix #(.W(WIDTH)) u_fix_a (
        .i_neg (w_a_neg),
        .i_val (a),
        .o_val (w_a_mag)
    );

    md_sign_fix #(.W(WIDTH)) u_fix_b (
        .i_neg (w_b_neg),
        .i_val (b),
        .o_val (w_b_mag)
    );

    md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .i_neg (r_neg_res),
        .i_val (r_acc),
        .o_val (w_prod_fix)
    );

    md_sign_fix #(.W(WIDTH)) u_fix_quo (
        .i_neg (r_neg_res),
        .i_val (r_quo),
        .o_val (w_quo_fix)
    );

    md_sign_fix #(.W(WIDTH)) u_fix_rem (
        .i_neg (r_neg_rem),
        .i_val (r_rem[WIDTH-1:0]),
        .o_val (w_rem_fix)
    );

    // Restoring step: a negative trial difference (top bit set) means restore.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {2'b00, r_opb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_IDLE: if (start) w_next = MD_CALC;
            MD_CALC: if (r_cnt == LAST) w_next = MD_FIX;
            MD_FIX:  w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
            r_a_orig  <= '0;
            r_opb     <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= (r_state == MD_FIX);
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_is_div  <= div_mul[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dbz     <= div_mul[1] && (b == '0);
                        r_a_orig  <= a;
                        r_opb     <= w_b_mag;
                        r_mcand   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_acc     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                    end
                end
                MD_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (!r_is_div) begin
                        if (r_opb[0]) r_acc <= r_acc + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_opb   <= r_opb >> 1;
                    end else if (w_trial[WIDTH+1]) begin
                        r_rem <= w_rem_sh[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end else begin
                        r_rem <= w_trial[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end
                end
                MD_FIX: begin
                    // Divide by zero reports the original dividend, bypassing sign fix.
                    if (r_dbz) begin
                        r_hi <= r_a_orig;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != MD_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
